// File: rtl/ble_feature_unpacker.sv
// rtl/ble_feature_unpacker.sv - BLE byte-stream deframer to signed 16-bit feature words
// Optional trailing XOR checksum byte is enabled by defining BLE_UNPACKER_CHECKSUM_EN.
module ble_feature_unpacker #(
    parameter int MAX_WORDS      = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [7:0]         ble_data_in,
    input  logic               ble_valid_in,
    output logic signed [15:0] feature_data_out,
    output logic               feature_valid_out,
    output logic               feature_last_out,
    input  logic               feature_ready_in,
    output logic               frame_ok_out,
    output logic               frame_err_out,
    output logic               overflow_out,
    output logic               busy_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    MAX_L  = 8'(MAX_WORDS);

`ifdef BLE_UNPACKER_CHECKSUM_EN
    typedef enum logic [2:0] {SYNC0, SYNC1, LEN, LO, HI, CSUM} state_t;
`else
    typedef enum logic [2:0] {SYNC0, SYNC1, LEN, LO, HI} state_t;
`endif

    state_t        state, state_nxt;
    logic [7:0]    wcnt, lo_byte;
    logic [TW-1:0] tcnt;
    logic          timeout, last_word, len_bad;
    logic [15:0]   word;
    logic          push, push_last, ok_nxt, err_nxt;
    logic [15:0]   push_data;

    logic [15:0]   mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push_ok;

    assign word      = {ble_data_in, lo_byte};
    assign last_word = (wcnt == 8'd1);
    assign len_bad   = (ble_data_in == 8'd0) || (ble_data_in > MAX_L);
    // An idle clock is one without a byte; the TIMEOUT_CYCLES-th consecutive one aborts.
    assign timeout   = (state != SYNC0) && !ble_valid_in && (tcnt >= T_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= SYNC0;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = SYNC0;
        end else if (ble_valid_in) begin
            case (state)
                SYNC0: if (ble_data_in == 8'hA5) state_nxt = SYNC1;
                SYNC1: begin
                    if (ble_data_in == 8'h5A)      state_nxt = LEN;
                    else if (ble_data_in != 8'hA5) state_nxt = SYNC0;
                end
                LEN:   state_nxt = len_bad ? SYNC0 : LO;
                LO:    state_nxt = HI;
`ifdef BLE_UNPACKER_CHECKSUM_EN
                HI:    state_nxt = last_word ? CSUM : LO;
                CSUM:  state_nxt = SYNC0;
`else
                HI:    state_nxt = last_word ? SYNC0 : LO;
`endif
                default: state_nxt = SYNC0;
            endcase
        end
    end

`ifdef BLE_UNPACKER_CHECKSUM_EN
    logic [7:0]  csum;
    logic [15:0] held;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            csum <= 8'd0;
            held <= 16'd0;
        end else if (ble_valid_in) begin
            if (state == LEN)                 csum <= ble_data_in;
            if (state == LO || state == HI)   csum <= csum ^ ble_data_in;
            if (state == HI && last_word)     held <= word;
        end
    end
`endif

    always_comb begin
        push      = 1'b0;
        push_data = word;
        push_last = 1'b0;
        ok_nxt    = 1'b0;
        err_nxt   = timeout;
        if (ble_valid_in) begin
            case (state)
                LEN: err_nxt = len_bad;
`ifdef BLE_UNPACKER_CHECKSUM_EN
                HI:  push = !last_word;
                CSUM: begin
                    push      = 1'b1;
                    push_data = held;
                    push_last = 1'b1;
                    ok_nxt    = (csum == ble_data_in);
                    err_nxt   = (csum != ble_data_in);
                end
`else
                HI: begin
                    push      = 1'b1;
                    push_last = last_word;
                    ok_nxt    = last_word;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wcnt          <= 8'd0;
            lo_byte       <= 8'd0;
            tcnt          <= '0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            overflow_out  <= 1'b0;
        end else begin
            frame_ok_out  <= ok_nxt;
            frame_err_out <= err_nxt;
            if (push && !push_ok) overflow_out <= 1'b1;
            if (ble_valid_in || state == SYNC0) tcnt <= '0;
            else if (tcnt != T_MAX)             tcnt <= tcnt + TW'(1);
            if (ble_valid_in) begin
                if (state == LEN) wcnt    <= ble_data_in;
                if (state == LO)  lo_byte <= ble_data_in;
                if (state == HI)  wcnt    <= wcnt - 8'd1;
            end
        end
    end

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && feature_ready_in;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_data[wr_ptr[AW-1:0]] <= push_data;
            mem_last[wr_ptr[AW-1:0]] <= push_last;
        end
    end

    assign feature_valid_out = !empty;
    assign feature_data_out  = empty ? 16'sd0 : $signed(mem_data[rd_ptr[AW-1:0]]);
    assign feature_last_out  = !empty && mem_last[rd_ptr[AW-1:0]];
    assign busy_out          = (state != SYNC0);

endmodule

// File: tb/tb_ble_feature_unpacker.sv
// tb/tb_ble_feature_unpacker.sv - directed self-checking bench for ble_feature_unpacker
`timescale 1ns/1ps
module tb_ble_feature_unpacker;
    localparam int TMO = 200;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         ble_data = 8'd0;
    logic               ble_valid = 1'b0;
    logic               ready = 1'b0;
    logic signed [15:0] fdata;
    logic               fvalid, flast, ok, err, ovf, busy;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    logic signed [15:0] got_w[$];
    logic               got_l[$];
    logic [15:0]        fw[16];

    always #5 clk = ~clk;

    ble_feature_unpacker #(.MAX_WORDS(64), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .ble_data_in(ble_data), .ble_valid_in(ble_valid),
        .feature_data_out(fdata), .feature_valid_out(fvalid), .feature_last_out(flast),
        .feature_ready_in(ready),
        .frame_ok_out(ok), .frame_err_out(err), .overflow_out(ovf), .busy_out(busy)
    );

    always @(negedge clk) begin
        if (ok) ok_cnt++;
        if (err) err_cnt++;
        if (fvalid && ready) begin
            got_w.push_back(fdata);
            got_l.push_back(flast);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        ble_data = b; ble_valid = 1'b1;
        @(posedge clk); #1;
        ble_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log;
        ok_cnt = 0; err_cnt = 0; got_w.delete(); got_l.delete();
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; ready = 1'b0; ble_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_log();
    endtask

    task automatic send_frame(input int n);
        logic [7:0] c;
        c = 8'(n);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][7:0]); send_byte(fw[i][15:8]);
            c = c ^ fw[i][7:0] ^ fw[i][15:8];
        end
`ifdef BLE_UNPACKER_CHECKSUM_EN
        send_byte(c);
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0; idle(2);
        checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fvalid); end
        checks++; if (flast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", flast); end
        checks++; if (fdata !== 16'sd0) begin errors++; $display("FAIL reset_data: got %h expected 0000", fdata); end
        checks++; if (ok !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ok=%b err=%b expected 0 0", ok, err); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1; idle(1); clear_log();
    endtask

    task automatic test_basic;
        clear_log(); ready = 1'b1;
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
        checks++; if (fvalid !== 1'b1 || fdata !== 16'sh1234) begin errors++; $display("FAIL basic_latency: got v=%b d=%h expected v=1 d=1234", fvalid, fdata); end
        send_byte(8'hCD); send_byte(8'hAB);
`ifdef BLE_UNPACKER_CHECKSUM_EN
        send_byte(8'h42);
`endif
        idle(4);
        checks++; if (got_w.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", got_w.size()); end
        checks++; if (got_w[0] !== 16'sh1234 || got_l[0] !== 1'b0) begin errors++; $display("FAIL basic_w0: got %h/%b expected 1234/0", got_w[0], got_l[0]); end
        checks++; if (got_w[1] !== -16'sd21555 || got_l[1] !== 1'b1) begin errors++; $display("FAIL basic_w1: got %0d/%b expected -21555/1", got_w[1], got_l[1]); end
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL basic_pulses: got ok=%0d err=%0d expected 1 0", ok_cnt, err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
    endtask

`ifdef BLE_UNPACKER_CHECKSUM_EN
    task automatic test_bad_checksum;
        clear_log(); ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02); send_byte(8'h34);
        send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h43);
        idle(4);
        checks++; if (got_w.size() !== 2 || got_l[1] !== 1'b1) begin errors++; $display("FAIL csum_words: got n=%0d last=%b expected 2 1", got_w.size(), got_l[1]); end
        checks++; if (ok_cnt !== 0 || err_cnt !== 1) begin errors++; $display("FAIL csum_pulses: got ok=%0d err=%0d expected 0 1", ok_cnt, err_cnt); end
    endtask
`endif

    task automatic test_len_errors;
        clear_log(); ready = 1'b1;
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h41);
        idle(4);
        checks++; if (err_cnt !== 2) begin errors++; $display("FAIL len_err_pulses: got %0d expected 2", err_cnt); end
        checks++; if (got_w.size() !== 0) begin errors++; $display("FAIL len_no_words: got %0d expected 0", got_w.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len_busy: got %b expected 0", busy); end
        clear_log();
        fw[0] = 16'h8000;
        send_frame(1); idle(4);
        checks++; if (got_w.size() !== 1 || got_w[0] !== -16'sd32768 || got_l[0] !== 1'b1) begin errors++; $display("FAIL len1_word: got n=%0d %h/%b expected 1 8000/1", got_w.size(), got_w[0], got_l[0]); end
        checks++; if (ok_cnt !== 1) begin errors++; $display("FAIL len1_ok: got %0d expected 1", ok_cnt); end
    endtask

    task automatic test_overflow;
        logic [7:0] c;
        apply_reset();
        c = 8'h0A;
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h0A);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i + 1)); send_byte(8'hC0);
            c = c ^ 8'(i + 1) ^ 8'hC0;
            checks++; if (ovf !== (i >= 8)) begin errors++; $display("FAIL overflow_word%0d: got %b expected %b", i, ovf, (i >= 8)); end
        end
`ifdef BLE_UNPACKER_CHECKSUM_EN
        send_byte(c);
`endif
        idle(2);
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL overflow_pulses: got ok=%0d err=%0d expected 1 0", ok_cnt, err_cnt); end
        checks++; if (fvalid !== 1'b1 || fdata !== 16'shC001) begin errors++; $display("FAIL overflow_head: got v=%b d=%h expected 1 c001", fvalid, fdata); end
        ready = 1'b1; idle(12);
        checks++; if (got_w.size() !== 8) begin errors++; $display("FAIL overflow_drain_count: got %0d expected 8", got_w.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_w[i] !== $signed(16'hC001 + 16'(i)) || got_l[i] !== 1'b0) begin errors++; $display("FAIL overflow_drain%0d: got %h/%b expected %h/0", i, got_w[i], got_l[i], 16'hC001 + 16'(i)); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_timeout;
        apply_reset(); ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        idle(TMO - 2);
        checks++; if (err_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got err=%0d busy=%b expected 0 1", err_cnt, busy); end
        idle(10);
        checks++; if (err_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_fire: got err=%0d busy=%b expected 1 0", err_cnt, busy); end
        checks++; if (got_w.size() !== 1 || got_w[0] !== 16'sh2211 || got_l[0] !== 1'b0) begin errors++; $display("FAIL timeout_word: got n=%0d %h/%b expected 1 2211/0", got_w.size(), got_w[0], got_l[0]); end
        clear_log();
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        send_frame(2); idle(4);
        checks++; if (got_w.size() !== 2 || got_w[1] !== -16'sd21555 || got_l[1] !== 1'b1 || ok_cnt !== 1) begin errors++; $display("FAIL timeout_recover: got n=%0d %h/%b ok=%0d expected 2 abcd/1 1", got_w.size(), got_w[1], got_l[1], ok_cnt); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02); send_byte(8'h34);
        send_byte(8'h12); send_byte(8'h78);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fvalid !== 1'b0 || fdata !== 16'sd0 || flast !== 1'b0) begin errors++; $display("FAIL midreset_out: got v=%b d=%h l=%b expected 0 0 0", fvalid, fdata, flast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h56);
        checks++; if (busy !== 1'b0 || fvalid !== 1'b0) begin errors++; $display("FAIL midreset_noise: got busy=%b v=%b expected 0 0", busy, fvalid); end
        clear_log(); ready = 1'b1;
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        send_frame(2); idle(4);
        checks++; if (got_w.size() !== 2 || got_w[0] !== 16'sh1234 || got_w[1] !== -16'sd21555 || ok_cnt !== 1) begin errors++; $display("FAIL midreset_recover: got n=%0d %h %h ok=%0d expected 2 1234 abcd 1", got_w.size(), got_w[0], got_w[1], ok_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef BLE_UNPACKER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_len_errors();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ble_feature_unpacker.md
# ble_feature_unpacker

Receive-side deframer for the Bluetooth UART byte stream. It takes the byte stream the Bluetooth block delivers (valid-only, no backpressure), finds framed feature packets, and reassembles little-endian signed 16-bit feature words. The words are presented on a ready/valid feature stream with `last`, the same stream format the feature extractor produces, so templates uploaded from the phone can feed the classifier path. It is the inverse of the feature-to-bytes packing done on the transmit side.

## Interface
Parameters:
- `MAX_WORDS`, 64: largest legal length field (words per frame); range 1..255.
- `FIFO_DEPTH`, 8: output FIFO entries (power of two, ≥2).
- `TIMEOUT_CYCLES`, 100000: idle clocks allowed between bytes inside a frame before abort.

Ports:
- `clk_in` input 1: clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `ble_data_in` input 8: received byte.
- `ble_valid_in` input 1: one-cycle strobe per byte; no ready, a byte is never stalled.
- `feature_data_out` output 16 signed: reassembled feature word.
- `feature_valid_out` output 1: word available.
- `feature_last_out` output 1: word is last of its frame.
- `feature_ready_in` input 1: consumer accepts on `valid && ready`.
- `frame_ok_out` output 1: one-cycle pulse, frame completed cleanly.
- `frame_err_out` output 1: one-cycle pulse, frame aborted or bad checksum.
- `overflow_out` output 1: sticky; a word was dropped because the FIFO was full.
- `busy_out` output 1: high in any state other than SYNC0.

## Operation
- Frame format: `0xA5 0x5A L w0_lo w0_hi … w(L-1)_lo w(L-1)_hi [C]`.
- FSM states: SYNC0, SYNC1, LEN, LO, HI, CSUM (CSUM only with the macro). All transitions happen only on `ble_valid_in` cycles, except timeout.
- SYNC0: 0xA5 → SYNC1. Any other byte is ignored.
- SYNC1: 0x5A → LEN. 0xA5 stays in SYNC1. Any other byte → SYNC0.
- LEN: if L==0 or L>MAX_WORDS, pulse `frame_err_out` and go to SYNC0. Otherwise load the word counter with L and go to LO.
- LO: latch the low byte, go to HI. Payload bytes are never interpreted as sync.
- HI: word = {hi, lo}; decrement the counter. If the counter is not yet zero, push the word with last=0 and go to LO.
- Final word, no macro: push with last=1, pulse `frame_ok_out`, go to SYNC0.
- Final word, with macro: handled as described under Configuration.
- Push when FIFO full:
  - The word is dropped and `overflow_out` is set.
  - The frame continues.
  - `frame_ok_out` still pulses at frame end.
  - `overflow_out` clears only on reset.
- Push and pop in the same cycle while full: both succeed, no overflow.
- Timeout: a counter clears on every byte. In any state other than SYNC0, reaching TIMEOUT_CYCLES idle clocks pulses `frame_err_out` and forces SYNC0. Words already pushed remain in the FIFO, and no `last` is emitted for that frame.
- Arithmetic: the word counter is 8 bits. The timeout counter width is $clog2(TIMEOUT_CYCLES+1) and saturates.

## Timing
- Reset values: `feature_valid_out`=0, `feature_last_out`=0, `feature_data_out`=0, `frame_ok_out`=0, `frame_err_out`=0, `overflow_out`=0, `busy_out`=0. The FIFO is empty and the FSM is in SYNC0.
- Reset asserted mid-frame clears everything immediately, including FIFO contents.
- Latency: a word is written at the clock edge that samples its HI byte (or its C byte, with the macro). `feature_valid_out` is high in the following cycle.
- `frame_ok_out` and `frame_err_out` are registered and high for exactly the cycle after the deciding byte, or the cycle after the timeout expires.
- Output is FIFO-head registered. `feature_data_out` and `feature_last_out` are stable while `valid && !ready`.
- Throughput: one word per cycle out. Input is at most one byte per cycle.

## Configuration
- Macro: `BLE_UNPACKER_CHECKSUM_EN`.
- Defined:
  - Frames carry a trailing byte C, equal to the XOR of L and all payload bytes.
  - The final word is held in a holding register, and HI goes to CSUM.
  - On the C byte, the held word is pushed with last=1 whether or not the checksum matches.
  - A match pulses `frame_ok_out`; a mismatch pulses `frame_err_out`. Either way the FSM goes to SYNC0.
  - The timeout also applies in CSUM, and the held word is discarded on timeout.
- Undefined: no CSUM state, no checksum logic, and the final word is pushed on its HI byte.

## Test plan
- Bytes A5 5A 02 34 12 CD AB (+42 with macro), ready=1 → words 0x1234 (last=0), then 0xABCD, i.e. −21555 (last=1); one `frame_ok_out` pulse.
- Macro build, same frame with C=0x43 → both words still output, last=1 on 0xABCD; `frame_err_out` pulses, `frame_ok_out` stays 0.
- Bytes A5 A5 5A 00, then A5 5A 41 (MAX_WORDS=64) → two `frame_err_out` pulses, no output words, FSM back in SYNC0.
- ready held 0, 10-word frame, FIFO_DEPTH=8 → first 8 words retained; `overflow_out`=1 from the 9th word onward; `frame_ok_out` still pulses. Releasing ready drains exactly the 8 words in order.
- A5 5A 03 11 22 then 100000 idle cycles → one word 0x2211 (last=0), then `frame_err_out`. A following clean frame decodes correctly.
- `rst_n_in` pulsed low between a LO and HI byte → all outputs 0 immediately. The subsequent HI byte is ignored as noise and the next valid frame decodes.
